// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG sharing controller.
// Holds the power-on seed and the sequencer state encoding.
package prng_pkg;

   localparam logic [31:0] SEED_DEFAULT = 32'h198837FA;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WARM  = 2'd1,
      SERVE = 2'd2
   } share_state_t;

   // The grant counter wraps silently from 16'hFFFF back to 0.
   function automatic logic [15:0] wrap_inc16(input logic [15:0] v);
      return v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Chooses the first eligible requester
// at or after ptr, wrapping modulo NREQ; outputs a one-hot pick and its index.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IW-1:0]   ptr,
   output logic            found,
   output logic [NREQ-1:0] pick,
   output logic [IW-1:0]   pick_idx
);

   // Scan from the farthest offset back to ptr so the nearest candidate wins.
   always_comb begin
      int k;
      found    = 1'b0;
      pick     = '0;
      pick_idx = '0;
      k        = 0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         k = (int'(ptr) + j) % NREQ;
         if (eligible[k]) begin
            found    = 1'b1;
            pick_idx = IW'(k);
         end
      end
      if (found) begin
         pick[pick_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/prng_share_ctrl.sv
// Sequences one cellular-automaton PRNG core (seed load, warm-up, serve)
// and hands each fresh core word to at most one requester, round-robin.
module prng_share_ctrl
   import prng_pkg::*;
#(
   parameter int          NREQ         = 4,
   parameter int          N            = 32,
   parameter int          WARMUP       = 16,
   parameter logic [N-1:0] SEED_DEFAULT = N'(prng_pkg::SEED_DEFAULT),
   localparam int         IW           = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] gnt,
   output logic [N-1:0]    rnd_data,
   output logic [IW-1:0]   rnd_owner,
   input  logic            reseed_req,
   input  logic [N-1:0]    reseed_seed,
   output logic            reseed_busy,
   output logic [15:0]     words_served,
   output logic            core_rst_n,
   output logic [N-1:0]    core_seed,
   input  logic [N-1:0]    core_data
);

   localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   share_state_t    state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   ptr;
   logic [NREQ-1:0] last_gnt;
   logic [NREQ-1:0] eligible;
   logic            found;
   logic [NREQ-1:0] pick;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   ptr_next;

   // The previous cycle's grant is still visible on gnt; a requester that
   // keeps req_valid high across its own grant must not be served twice in a row.
   assign last_gnt = gnt;
   assign eligible = req_valid & ~last_gnt;
   assign ptr_next = IW'((int'(pick_idx) + 1) % NREQ);

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr_arbiter (
      .eligible (eligible),
      .ptr      (ptr),
      .found    (found),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= LOAD;
         cnt          <= '0;
         ptr          <= '0;
         gnt          <= '0;
         rnd_data     <= '0;
         rnd_owner    <= '0;
         reseed_busy  <= 1'b1;
         core_rst_n   <= 1'b0;
         core_seed    <= SEED_DEFAULT;
         words_served <= '0;
      end else begin
         gnt <= '0;
         unique case (state)
            LOAD: begin
               // core_rst_n is low during this cycle, so the core loads core_seed
               // on this edge; a fresh reseed request keeps it low one more cycle.
               if (reseed_req) begin
                  core_seed <= reseed_seed;
               end else begin
                  state      <= WARM;
                  cnt        <= '0;
                  core_rst_n <= 1'b1;
               end
            end
            WARM: begin
               if (reseed_req) begin
                  state      <= LOAD;
                  core_seed  <= reseed_seed;
                  core_rst_n <= 1'b0;
                  cnt        <= '0;
               end else if (cnt == CW'(WARMUP - 1)) begin
                  state       <= SERVE;
                  reseed_busy <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SERVE: begin
               // A reseed takes priority: no word of the old sequence is handed out.
               if (reseed_req) begin
                  state       <= LOAD;
                  core_seed   <= reseed_seed;
                  core_rst_n  <= 1'b0;
                  reseed_busy <= 1'b1;
               end else if (found) begin
                  gnt          <= pick;
                  rnd_owner    <= pick_idx;
                  rnd_data     <= core_data;
                  ptr          <= ptr_next;
                  words_served <= wrap_inc16(words_served);
               end
            end
            default: begin
               state       <= LOAD;
               core_rst_n  <= 1'b0;
               reseed_busy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Randomised and directed bench for prng_share_ctrl with a behavioural
// CA core on the core_* ports and a timeline-level reference model.
module tb_prng_share_ctrl;

   localparam int          NREQ   = 4;
   localparam int          N      = 32;
   localparam int          WARMUP = 16;
   localparam int          LOADW  = WARMUP + 1;
   localparam logic [31:0] SEED0  = 32'h198837FA;
   localparam logic [31:0] R150   = 32'hA5C31E69;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] gnt;
   logic [N-1:0]    rnd_data;
   logic [1:0]      rnd_owner;
   logic            reseed_req;
   logic [N-1:0]    reseed_seed;
   logic            reseed_busy;
   logic [15:0]     words_served;
   logic            core_rst_n;
   logic [N-1:0]    core_seed;
   logic [N-1:0]    core_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prng_share_ctrl #(
      .NREQ(NREQ), .N(N), .WARMUP(WARMUP), .SEED_DEFAULT(SEED0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .gnt(gnt),
      .rnd_data(rnd_data), .rnd_owner(rnd_owner), .reseed_req(reseed_req),
      .reseed_seed(reseed_seed), .reseed_busy(reseed_busy),
      .words_served(words_served), .core_rst_n(core_rst_n),
      .core_seed(core_seed), .core_data(core_data)
   );

   // Hybrid rule-90/150 cellular automaton, null boundaries.
   function automatic logic [31:0] ca_step(input logic [31:0] s);
      return {s[30:0], 1'b0} ^ {1'b0, s[31:1]} ^ (s & R150);
   endfunction

   function automatic logic [31:0] ca_pow(input logic [31:0] s, input int k);
      logic [31:0] v = s;
      for (int i = 0; i < k; i++) v = ca_step(v);
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (!core_rst_n) core_data <= core_seed;
      else             core_data <= ca_step(core_data);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: m_wait counts edges until arbitration is allowed again,
   // m_age counts core steps since the last seed load.
   int              m_wait;
   logic [31:0]     m_seed, m_lseed, m_data;
   int              m_age, m_ptr, m_own, m_ws;
   logic [NREQ-1:0] m_gnt;
   logic [31:0]     pre_core;

   task automatic model_step(input logic [NREQ-1:0] rq, input logic rs,
                             input logic [31:0] sd, input logic rn);
      int              w0;
      logic [31:0]     s0;
      logic [NREQ-1:0] elig, newg;
      if (!rn) begin
         m_wait = LOADW; m_seed = SEED0; m_lseed = SEED0; m_age = 0;
         m_ptr = 0; m_gnt = '0; m_data = '0; m_own = 0; m_ws = 0;
      end else begin
         w0 = m_wait; s0 = m_seed; newg = '0;
         elig = rq & ~m_gnt;
         if (rs) begin
            m_wait = LOADW; m_seed = sd;
         end else if (w0 > 0) begin
            m_wait = w0 - 1;
         end else begin
            for (int j = 0; j < NREQ; j++) begin
               int k;
               k = (m_ptr + j) % NREQ;
               if (elig[k] && newg == '0) begin
                  newg[k] = 1'b1;
                  m_own   = k;
                  m_data  = ca_pow(m_lseed, m_age);
                  m_ptr   = (k + 1) % NREQ;
                  m_ws    = (m_ws + 1) % 65536;
               end
            end
         end
         if (w0 == LOADW) begin
            m_lseed = s0; m_age = 0;
         end else begin
            m_age++;
         end
         m_gnt = newg;
      end
   endtask

   task automatic cycle(input logic [NREQ-1:0] rq, input logic rs,
                        input logic [31:0] sd, input logic rn);
      reset_n = rn; req_valid = rq; reseed_req = rs; reseed_seed = sd;
      pre_core = core_data;
      model_step(rq, rs, sd, rn);
      @(posedge clk); #1;
      check_eq("gnt", 64'(gnt), 64'(m_gnt));
      check_eq("rnd_owner", 64'(rnd_owner), 64'(m_own));
      check_eq("rnd_data", 64'(rnd_data), 64'(m_data));
      check_eq("reseed_busy", 64'(reseed_busy), 64'(m_wait != 0));
      check_eq("core_rst_n", 64'(core_rst_n), 64'(m_wait != LOADW));
      check_eq("core_seed", 64'(core_seed), 64'(m_seed));
      check_eq("words_served", 64'(words_served), 64'(m_ws));
   endtask

   initial begin
      int              first;
      logic [31:0]     prev;
      logic [NREQ-1:0] rq;
      logic            have_prev;
      reset_n = 1'b0; req_valid = '0; reseed_req = 1'b0; reseed_seed = '0;
      m_wait = LOADW; m_seed = SEED0; m_lseed = SEED0; m_age = 0;
      m_ptr = 0; m_gnt = '0; m_data = '0; m_own = 0; m_ws = 0;

      // Test 1: single held requester after reset
      cycle('0, 1'b0, '0, 1'b0);
      cycle('0, 1'b0, '0, 1'b0);
      first = -1;
      for (int i = 1; i <= 40; i++) begin
         cycle(4'b0001, 1'b0, '0, 1'b1);
         if (gnt != '0) begin
            if (first < 0) first = i;
            check_eq("t1_data_vs_core", 64'(rnd_data), 64'(pre_core));
         end
      end
      check_eq("t1_first_gnt_edge", 64'(first), 64'(18));

      // Test 2: all four requesters held
      have_prev = 1'b0; prev = '0;
      for (int i = 0; i < 24; i++) begin
         cycle(4'b1111, 1'b0, '0, 1'b1);
         if (gnt != '0) begin
            if (have_prev) check_eq("t2_distinct", 64'(rnd_data == prev), 64'(0));
            prev = rnd_data; have_prev = 1'b1;
         end
      end

      // Test 3: reseed while serving
      cycle(4'b1111, 1'b1, 32'hFACD1223, 1'b1);
      check_eq("t3_busy", 64'(reseed_busy), 64'(1));
      check_eq("t3_seed", 64'(core_seed), 64'(32'hFACD1223));
      first = -1;
      for (int i = 1; i <= 30; i++) begin
         cycle(4'b1111, 1'b0, '0, 1'b1);
         if (gnt != '0 && first < 0) first = i;
      end
      check_eq("t3_first_gnt_edge", 64'(first), 64'(18));

      // Test 4: reseed again in the middle of warm-up (cnt==7)
      cycle(4'b1111, 1'b1, $urandom, 1'b1);
      for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0, '0, 1'b1);
      cycle(4'b1111, 1'b1, $urandom, 1'b1);
      check_eq("t4_core_rst_n", 64'(core_rst_n), 64'(0));
      first = -1;
      for (int i = 1; i <= 30; i++) begin
         cycle(4'b1111, 1'b0, '0, 1'b1);
         if (gnt != '0 && first < 0) first = i;
      end
      check_eq("t4_first_gnt_edge", 64'(first), 64'(18));

      // Test 5: pointer at 3, requesters 1,2 then 3
      for (int i = 0; i < 6 && !(gnt == 4'b0100); i++) cycle(4'b0100, 1'b0, '0, 1'b1);
      check_eq("t5_setup", 64'(gnt), 64'(4'b0100));
      cycle(4'b0000, 1'b0, '0, 1'b1);
      cycle(4'b0110, 1'b0, '0, 1'b1);
      check_eq("t5_owner_a", 64'(rnd_owner), 64'(1));
      cycle(4'b0100, 1'b0, '0, 1'b1);
      check_eq("t5_owner_b", 64'(rnd_owner), 64'(2));
      cycle(4'b1100, 1'b0, '0, 1'b1);
      check_eq("t5_owner_c", 64'(gnt), 64'(4'b1000));

      // Test 6: reset in the middle of a burst
      for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, '0, 1'b1);
      cycle(4'b1111, 1'b0, '0, 1'b0);
      check_eq("t6_gnt", 64'(gnt), 64'(0));
      check_eq("t6_busy", 64'(reseed_busy), 64'(1));
      check_eq("t6_core_rst_n", 64'(core_rst_n), 64'(0));
      check_eq("t6_words", 64'(words_served), 64'(0));
      first = -1;
      for (int i = 1; i <= 25; i++) begin
         cycle(4'b1111, 1'b0, '0, 1'b1);
         if (gnt != '0 && first < 0) begin
            first = i;
            check_eq("t6_first_owner", 64'(rnd_owner), 64'(0));
         end
      end
      check_eq("t6_first_gnt_edge", 64'(first), 64'(18));

      // Random traffic with occasional reseeds and resets
      rq = '0;
      for (int i = 0; i < 900; i++) begin
         logic rs, rn;
         for (int b = 0; b < NREQ; b++) begin
            if (rq[b] && m_gnt[b] && ($urandom_range(1, 0) == 0)) rq[b] = 1'b0;
            else if (!rq[b] && ($urandom_range(2, 0) == 0)) rq[b] = 1'b1;
         end
         rs = ($urandom_range(59, 0) == 0);
         rn = ($urandom_range(199, 0) != 0);
         cycle(rq, rs, $urandom, rn);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
